screen_sequencer: RTL and testbench

- Top-level screen scheduler for the drag-racing video path; sequences MENU -> COUNTDOWN -> RACE -> RESULT -> MENU.
- Drives the screen-select mux between the game menu pipeline and the race and result pipelines.
- Consumes the menu's start_game_flag and produces back_to_main_menu_flag.
- All screen changes are frame-aligned. A switch takes effect only on a vertical-blank start, so no torn frames.

---
 rtl/screen_pkg.sv | 26 ++
 rtl/frame_tick_gen.sv | 31 +++
 rtl/screen_sequencer.sv | 170 +++++++++++++++++
 tb/tb_screen_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared encodings for the screen sequencer: screen states (also the screen_sel
// values), key codes, winner codes and the pending-request bundle.
package screen_pkg;

    typedef enum logic [1:0] {
        SCR_MENU      = 2'd0,
        SCR_COUNTDOWN = 2'd1,
        SCR_RACE      = 2'd2,
        SCR_RESULT    = 2'd3
    } screen_e;

    localparam logic [2:0] KEY_ENTER = 3'd4;
    localparam logic [2:0] KEY_ESC   = 3'd5;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    typedef struct packed {
        logic start;
        logic esc;
        logic enter;
        logic fin;
    } pend_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Registered rising-edge detector on vertical blank; frame_tick pulses the cycle
// after vblnk_in rises.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vblnk_in,
    output logic frame_tick
);

    logic vblnk_q, vblnk_d;
    logic tick_q, tick_d;

    always_comb begin
        vblnk_d = vblnk_in;
        tick_d  = vblnk_in & ~vblnk_q;
    end

    // vblnk_q resets high so a blank already asserted at reset release is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_q <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            vblnk_q <= vblnk_d;
            tick_q  <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/screen_sequencer.sv
// Frame-aligned screen scheduler: MENU -> COUNTDOWN -> RACE -> RESULT -> MENU,
// with requests latched between vertical-blank ticks.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC      = 60,
    parameter int unsigned COUNT_START         = 3,
    parameter int unsigned RACE_TIMEOUT_FRAMES = 3600,
    parameter int unsigned RESULT_FRAMES       = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk_in,
    input  logic [2:0] keyboard_in,
    input  logic       start_game_flag,
    input  logic       race_finished,
    input  logic [1:0] race_winner,
    output logic [1:0] screen_sel,
    output logic       race_enable,
    output logic [3:0] countdown_digit,
    output logic [1:0] winner_out,
    output logic       back_to_main_menu_flag
);

    localparam int unsigned MAX_A = (RACE_TIMEOUT_FRAMES > RESULT_FRAMES) ? RACE_TIMEOUT_FRAMES : RESULT_FRAMES;
    localparam int unsigned MAX_F = (MAX_A > FRAMES_PER_SEC) ? MAX_A : FRAMES_PER_SEC;
    localparam int unsigned CNT_W = (MAX_F > 2) ? $clog2(MAX_F) : 1;
    localparam int unsigned DIG_W = 4;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_F - 1);
    localparam logic [CNT_W-1:0] FPS_LAST  = CNT_W'(FRAMES_PER_SEC - 1);
    localparam logic [CNT_W-1:0] RACE_LAST = CNT_W'(RACE_TIMEOUT_FRAMES - 1);
    localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(RESULT_FRAMES - 1);

    logic frame_tick;

    frame_tick_gen u_tick (
        .clk        (clk),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .frame_tick (frame_tick)
    );

    screen_e          state_q, state_d;
    pend_t            pend_q, pend_d, pend_now;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [DIG_W-1:0] digit_q, digit_d;
    logic [1:0]       win_cap_q, win_cap_d;
    logic [1:0]       winner_q, winner_d;
    logic             start_prev_q, start_prev_d;
    logic             back_q, back_d;
    logic [1:0]       screen_sel_q, screen_sel_d;
    logic             race_enable_q, race_enable_d;
    logic [DIG_W-1:0] digit_out_q, digit_out_d;

    always_comb begin
        start_prev_d   = start_game_flag;
        pend_now.start = pend_q.start | (start_game_flag & ~start_prev_q);
        pend_now.esc   = pend_q.esc   | (keyboard_in == KEY_ESC);
        pend_now.enter = pend_q.enter | (keyboard_in == KEY_ENTER);
        pend_now.fin   = pend_q.fin   | race_finished;
        win_cap_d      = race_finished ? race_winner : win_cap_q;
        cnt_inc        = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        state_d  = state_q;
        pend_d   = pend_now;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        winner_d = winner_q;
        back_d   = 1'b0;

        // Every tick consumes all pending requests, so none leak into the next screen
        if (frame_tick) begin
            pend_d = '0;
            case (state_q)
                SCR_MENU: begin
                    if (pend_now.start) begin
                        state_d = SCR_COUNTDOWN;
                        digit_d = DIG_W'(COUNT_START);
                        cnt_d   = '0;
                    end
                end
                SCR_COUNTDOWN: begin
                    if (pend_now.esc) begin
                        state_d = SCR_MENU;
                        back_d  = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == FPS_LAST) begin
                        cnt_d = '0;
                        if (digit_q <= DIG_W'(1)) begin
                            state_d  = SCR_RACE;
                            digit_d  = '0;
                            winner_d = WIN_NONE;
                        end else begin
                            digit_d = digit_q - DIG_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SCR_RACE: begin
                    if (pend_now.fin) begin
                        state_d  = SCR_RESULT;
                        winner_d = win_cap_d;
                        cnt_d    = '0;
                    end else if (pend_now.esc) begin
                        state_d = SCR_MENU;
                        back_d  = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == RACE_LAST) begin
                        state_d  = SCR_RESULT;
                        winner_d = WIN_NONE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SCR_RESULT: begin
                    if (pend_now.enter || (cnt_q == RES_LAST)) begin
                        state_d = SCR_MENU;
                        back_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = SCR_MENU;
            endcase
        end

        screen_sel_d  = state_d;
        race_enable_d = (state_d == SCR_RACE);
        digit_out_d   = (state_d == SCR_COUNTDOWN) ? digit_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SCR_MENU;
            pend_q        <= '0;
            cnt_q         <= '0;
            digit_q       <= '0;
            win_cap_q     <= WIN_NONE;
            winner_q      <= WIN_NONE;
            start_prev_q  <= 1'b1;
            back_q        <= 1'b0;
            screen_sel_q  <= 2'd0;
            race_enable_q <= 1'b0;
            digit_out_q   <= '0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            win_cap_q     <= win_cap_d;
            winner_q      <= winner_d;
            start_prev_q  <= start_prev_d;
            back_q        <= back_d;
            screen_sel_q  <= screen_sel_d;
            race_enable_q <= race_enable_d;
            digit_out_q   <= digit_out_d;
        end
    end

    assign screen_sel             = screen_sel_q;
    assign race_enable            = race_enable_q;
    assign countdown_digit        = digit_out_q;
    assign winner_out             = winner_q;
    assign back_to_main_menu_flag = back_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed table-driven bench for screen_sequencer with small frame constants.
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       vblnk_in;
    logic [2:0] keyboard_in;
    logic       start_game_flag;
    logic       race_finished;
    logic [1:0] race_winner;
    logic [1:0] screen_sel;
    logic       race_enable;
    logic [3:0] countdown_digit;
    logic [1:0] winner_out;
    logic       back_to_main_menu_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;

    screen_sequencer #(
        .FRAMES_PER_SEC      (4),
        .COUNT_START         (3),
        .RACE_TIMEOUT_FRAMES (20),
        .RESULT_FRAMES       (8)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .vblnk_in               (vblnk_in),
        .keyboard_in            (keyboard_in),
        .start_game_flag        (start_game_flag),
        .race_finished          (race_finished),
        .race_winner            (race_winner),
        .screen_sel             (screen_sel),
        .race_enable            (race_enable),
        .countdown_digit        (countdown_digit),
        .winner_out             (winner_out),
        .back_to_main_menu_flag (back_to_main_menu_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (back_to_main_menu_flag === 1'b1) pulse_cnt++;

    typedef struct {
        logic       start;
        logic [2:0] key;
        logic       fin;
        logic [1:0] win_in;
        int         nf;
        logic [1:0] sel;
        logic       en;
        logic [3:0] dig;
        logic [1:0] wout;
        int         pulses;
    } vec_t;

    vec_t vecs[$];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One frame: blank high for two cycles (tick lands inside), low for two
    task automatic frame();
        vblnk_in = 1'b1;
        cyc(2);
        vblnk_in = 1'b0;
        cyc(2);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] sel, input logic en,
                            input logic [3:0] dig, input logic [1:0] wout);
        chk({tag, " screen_sel"}, 32'(screen_sel), 32'(sel));
        chk({tag, " race_enable"}, 32'(race_enable), 32'(en));
        chk({tag, " countdown_digit"}, 32'(countdown_digit), 32'(dig));
        chk({tag, " winner_out"}, 32'(winner_out), 32'(wout));
    endtask

    initial begin
        int p0;
        string tag;
        //                 st   key   fin  win  nf  sel  en   dig  wout pulses
        vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd0, 0}); // 0 idle menu
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 0, 2'd0, 1'b0, 4'd0, 2'd0, 0}); // 1 start mid-frame
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd1, 1'b0, 4'd3, 2'd0, 0}); // 2 countdown entry
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 3, 2'd1, 1'b0, 4'd3, 2'd0, 0}); // 3 digit 3 held
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd1, 1'b0, 4'd2, 2'd0, 0}); // 4 tick 4
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 4, 2'd1, 1'b0, 4'd1, 2'd0, 0}); // 5 tick 8
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 3, 2'd1, 1'b0, 4'd1, 2'd0, 0}); // 6 tick 11
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd2, 1'b1, 4'd0, 2'd0, 0}); // 7 tick 12 race
        vecs.push_back('{1'b1, 3'd5, 1'b1, 2'd2, 1, 2'd3, 1'b0, 4'd0, 2'd2, 0}); // 8 fin beats esc
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 2, 2'd3, 1'b0, 4'd0, 2'd2, 0}); // 9 result ticks 1-2
        vecs.push_back('{1'b1, 3'd4, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd2, 1}); // 10 enter on tick 3
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 2, 2'd0, 1'b0, 4'd0, 2'd2, 0}); // 11 start still high
        vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd2, 0}); // 12 start dropped
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd1, 1'b0, 4'd3, 2'd2, 0}); // 13 new rise
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 12, 2'd2, 1'b1, 4'd0, 2'd0, 0}); // 14 race, winner cleared
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 19, 2'd2, 1'b1, 4'd0, 2'd0, 0}); // 15 before timeout
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd3, 1'b0, 4'd0, 2'd0, 0}); // 16 timeout
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 7, 2'd3, 1'b0, 4'd0, 2'd0, 0}); // 17 result held
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd0, 1}); // 18 auto-return
        vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd0, 0}); // 19
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd1, 1'b0, 4'd3, 2'd0, 0}); // 20
        vecs.push_back('{1'b1, 3'd5, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd0, 1}); // 21 esc in countdown
        vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd0, 0}); // 22
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd1, 1'b0, 4'd3, 2'd0, 0}); // 23
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 12, 2'd2, 1'b1, 4'd0, 2'd0, 0}); // 24
        vecs.push_back('{1'b1, 3'd5, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd0, 1}); // 25 esc in race
        vecs.push_back('{1'b0, 3'd0, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd0, 0}); // 26
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 1, 2'd1, 1'b0, 4'd3, 2'd0, 0}); // 27
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 12, 2'd2, 1'b1, 4'd0, 2'd0, 0}); // 28
        vecs.push_back('{1'b1, 3'd0, 1'b1, 2'd1, 1, 2'd3, 1'b0, 4'd0, 2'd1, 0}); // 29 P1 wins
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 8, 2'd0, 1'b0, 4'd0, 2'd1, 1}); // 30 auto-return
        vecs.push_back('{1'b0, 3'd5, 1'b0, 2'd0, 1, 2'd0, 1'b0, 4'd0, 2'd1, 0}); // 31 esc ignored in menu
        vecs.push_back('{1'b1, 3'd0, 1'b0, 2'd0, 13, 2'd2, 1'b1, 4'd0, 2'd0, 0}); // 32 into race

        rst = 1'b1;
        vblnk_in = 1'b0;
        keyboard_in = 3'd0;
        start_game_flag = 1'b0;
        race_finished = 1'b0;
        race_winner = 2'd0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk_outs("reset", 2'd0, 1'b0, 4'd0, 2'd0);
        chk("reset pulses", 32'(pulse_cnt), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            tag = $sformatf("vec%0d", i);
            start_game_flag = vecs[i].start;
            cyc(1);
            if (vecs[i].key != 3'd0 || vecs[i].fin) begin
                keyboard_in   = vecs[i].key;
                race_finished = vecs[i].fin;
                race_winner   = vecs[i].win_in;
                cyc(1);
                keyboard_in   = 3'd0;
                race_finished = 1'b0;
                race_winner   = 2'd0;
            end
            p0 = pulse_cnt;
            repeat (vecs[i].nf) frame();
            chk_outs(tag, vecs[i].sel, vecs[i].en, vecs[i].dig, vecs[i].wout);
            chk({tag, " pulses"}, 32'(pulse_cnt - p0), 32'(vecs[i].pulses));
        end

        // Reset mid-race with vblank high across reset
        p0 = pulse_cnt;
        vblnk_in = 1'b1;
        rst = 1'b1;
        start_game_flag = 1'b0;
        cyc(1);
        chk_outs("midrace_rst", 2'd0, 1'b0, 4'd0, 2'd0);
        cyc(2);
        rst = 1'b0;
        cyc(1);
        start_game_flag = 1'b1;
        cyc(4);
        chk("no_tick_after_rst screen_sel", 32'(screen_sel), 32'd0);
        chk("midrace_rst pulses", 32'(pulse_cnt - p0), 32'd0);
        vblnk_in = 1'b0;
        cyc(2);
        vblnk_in = 1'b1;
        cyc(2);
        chk("first_tick screen_sel", 32'(screen_sel), 32'd1);
        chk("first_tick countdown_digit", 32'(countdown_digit), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
